// File: rtl/hdlcsend.sv
// ---------------------------------------------------------------------------
// hdlcsend - HDLC frame transmitter
//
// Reads a byte count and a payload from a synchronous transmit buffer RAM and
// serialises one HDLC frame onto datat, one bit per clkt cycle:
//   NFLAGS opening 8'h7E flags, payload LSB first with zero-bit stuffing,
//   16-bit complemented CRC-16-CCITT FCS (stuffed), one closing 8'h7E flag.
//
// Ports
//   clkt        in   transmit bit clock, everything on the rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   one-cycle send request, ignored while busy
//   ramd[7:0]   in   buffer read data, valid the cycle after hrd
//   rama[AW-1:0]out  buffer read address
//   hrd         out  buffer read strobe (one cycle per read)
//   datat       out  serial bit stream, idles at 1
//   flagt       out  high for every bit of the frame, first flag to last flag
//   busy        out  high from start acceptance until done
//   done        out  one-cycle completion pulse (also for an empty request)
//   o_dbg_state out  current FSM state encoding
//
// Handshake: start is sampled only in IDLE (busy=0). Once accepted, busy
// rises the next cycle and stays high until the cycle done pulses; done and
// the falling edge of busy coincide. A start seen while busy=1 has no effect.
// ---------------------------------------------------------------------------
module hdlcsend #(
  parameter int unsigned       NFLAGS   = 2,
  parameter int unsigned       ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] LEN_ADDR = 9'd511
) (
  input  logic              clkt,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        ramd,
  output logic [ADDR_W-1:0] rama,
  output logic              hrd,
  output logic              datat,
  output logic              flagt,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_RD  = 3'd1,
    LEN_CAP = 3'd2,
    FLAG_O  = 3'd3,
    DATA    = 3'd4,
    FCS     = 3'd5,
    FLAG_C  = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [7:0]  FLAG      = 8'h7E;
  localparam logic [5:0]  FLAG_BITS = 6'(NFLAGS * 8);
  localparam logic [15:0] CRC_POLY  = 16'h1021;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rama;
  logic                r_hrd;
  logic                r_datat;
  logic                r_flagt;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_pend;  // a read was issued last cycle; ramd valid now
  logic [7:0]          r_nbuf;     // next payload byte, captured from ramd
  logic [7:0]          r_left;     // payload bytes not yet loaded into the shifter
  logic [7:0]          r_sh;       // payload shifter, bit 0 goes out next
  logic [2:0]          r_nbits;    // bits still waiting in the shifter
  logic [2:0]          r_ones;     // consecutive 1s on the wire (DATA/FCS only)
  logic [15:0]         r_crc;      // CRC register, reused as FCS shifter
  logic [5:0]          r_bcnt;     // flag bit index / FCS bits remaining
  logic                w_load;     // emit bit 0 of r_nbuf and refill the shifter

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  function automatic logic [2:0] ones_next(input logic [2:0] o, input logic b);
    return b ? (o + 3'd1) : 3'd0;
  endfunction

  // A byte is loaded either right after the last opening flag bit (the
  // prefetched byte 0 is already waiting) or when the shifter runs dry in
  // DATA with bytes remaining. A pending stuff bit always goes first.
  always_comb begin
    w_load = 1'b0;
    if (r_state == FLAG_O)
      w_load = (r_bcnt == FLAG_BITS);
    else if (r_state == DATA)
      w_load = (r_ones != 3'd5) && (r_nbits == 3'd0) && (r_left != 8'd0);
  end

  always_ff @(posedge clkt) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rama    <= '0;
      r_hrd     <= 1'b0;
      r_datat   <= 1'b1;
      r_flagt   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_nbuf    <= 8'd0;
      r_left    <= 8'd0;
      r_sh      <= 8'd0;
      r_nbits   <= 3'd0;
      r_ones    <= 3'd0;
      r_crc     <= 16'd0;
      r_bcnt    <= 6'd0;
    end else begin
      r_hrd     <= 1'b0;
      r_done    <= 1'b0;
      r_rd_pend <= r_hrd;
      if (r_rd_pend)
        r_nbuf <= ramd;

      case (r_state)
        IDLE: begin
          r_datat <= 1'b1;
          if (start) begin
            r_rama  <= LEN_ADDR;
            r_hrd   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LEN_RD;
          end
        end

        LEN_RD: r_state <= LEN_CAP;

        LEN_CAP: begin
          if (ramd == 8'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // Prefetch byte 0 now; the opening flags cover the RAM latency.
            r_left  <= ramd;
            r_nbits <= 3'd0;
            r_rama  <= '0;
            r_hrd   <= 1'b1;
            r_crc   <= 16'hFFFF;
            r_ones  <= 3'd0;
            r_flagt <= 1'b1;
            r_datat <= FLAG[0];
            r_bcnt  <= 6'd1;
            r_state <= FLAG_O;
          end
        end

        FLAG_O: begin
          if (r_bcnt != FLAG_BITS) begin
            r_datat <= FLAG[r_bcnt[2:0]];
            r_bcnt  <= r_bcnt + 6'd1;
          end
        end

        DATA: begin
          if (r_ones == 3'd5) begin
            // Stuffed zero: shifter and CRC hold for this cycle.
            r_datat <= 1'b0;
            r_ones  <= 3'd0;
          end else if (r_nbits != 3'd0) begin
            r_datat <= r_sh[0];
            r_crc   <= crc_step(r_crc, r_sh[0]);
            r_ones  <= ones_next(r_ones, r_sh[0]);
            r_sh    <= {1'b0, r_sh[7:1]};
            r_nbits <= r_nbits - 3'd1;
          end else if (r_left == 8'd0) begin
            // Payload exhausted: first FCS bit is the complemented CRC MSB.
            r_datat <= ~r_crc[15];
            r_ones  <= ones_next(r_ones, ~r_crc[15]);
            r_crc   <= {r_crc[14:0], 1'b0};
            r_bcnt  <= 6'd15;
            r_state <= FCS;
          end
        end

        FCS: begin
          if (r_ones == 3'd5) begin
            // Also covers a run of five ending on the last FCS bit.
            r_datat <= 1'b0;
            r_ones  <= 3'd0;
          end else if (r_bcnt != 6'd0) begin
            r_datat <= ~r_crc[15];
            r_ones  <= ones_next(r_ones, ~r_crc[15]);
            r_crc   <= {r_crc[14:0], 1'b0};
            r_bcnt  <= r_bcnt - 6'd1;
          end else begin
            r_datat <= FLAG[0];
            r_bcnt  <= 6'd1;
            r_state <= FLAG_C;
          end
        end

        FLAG_C: begin
          if (r_bcnt == 6'd8) begin
            r_datat <= 1'b1;
            r_flagt <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_datat <= FLAG[r_bcnt[2:0]];
            r_bcnt  <= r_bcnt + 6'd1;
          end
        end

        DONE: begin
          r_datat <= 1'b1;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_datat <= r_nbuf[0];
        r_crc   <= crc_step(r_crc, r_nbuf[0]);
        r_ones  <= ones_next(r_ones, r_nbuf[0]);
        r_sh    <= {1'b0, r_nbuf[7:1]};
        r_nbits <= 3'd7;
        r_left  <= r_left - 8'd1;
        // Fetch the following byte only if one remains; it arrives long
        // before the 8 bits of the current byte have gone out.
        if (r_left != 8'd1) begin
          r_rama <= r_rama + 1'b1;
          r_hrd  <= 1'b1;
        end
        r_state <= DATA;
      end
    end
  end

  assign rama        = r_rama;
  assign hrd         = r_hrd;
  assign datat       = r_datat;
  assign flagt       = r_flagt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hdlcsend.sv
// ---------------------------------------------------------------------------
// tb_hdlcsend - directed bench for hdlcsend.
// Buffer RAM model, negedge monitor capturing the flagt window, a stuffed
// expected bit stream built from the buffer contents, and a destuffing
// decoder with an independent CRC residue check.
// ---------------------------------------------------------------------------
module tb_hdlcsend;
  localparam int         NFL  = 2;
  localparam logic [7:0] FLAG = 8'h7E;

  logic       clkt = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ramd = 8'd0;
  logic [8:0] rama;
  logic       hrd, datat, flagt, busy, done;
  logic [2:0] dbg_state;

  logic [7:0] mem [0:511];

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];
  logic [0:0] bit_q[$];
  int         hrd_q[$];
  int         done_cnt = 0;
  int         idle_bad = 0;
  bit         mon_en = 1'b0;

  hdlcsend #(.NFLAGS(NFL), .ADDR_W(9), .LEN_ADDR(9'd511)) dut (
    .clkt(clkt), .rst_n(rst_n), .start(start), .ramd(ramd),
    .rama(rama), .hrd(hrd), .datat(datat), .flagt(flagt),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clkt = ~clkt;

  // ---- synchronous buffer RAM ----
  always @(posedge clkt) if (hrd) ramd <= mem[rama];

  // ---- monitor ----
  always @(negedge clkt) begin
    if (mon_en) begin
      if (flagt) bit_q.push_back(datat);
      else if (datat !== 1'b1) idle_bad++;
      if (done) done_cnt++;
      if (hrd) hrd_q.push_back(int'(rama));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    crc_upd = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Expected wire stream for a buffer holding len bytes in mem[0..len-1].
  task automatic build_exp(input int len);
    logic [0:0] raw[$];
    logic [7:0] fl;
    logic [7:0] byt;
    logic [15:0] crc;
    logic [15:0] fcs;
    int ones;
    exp_q.delete();
    fl = FLAG;
    if (len == 0) return;
    for (int f = 0; f < NFL; f++)
      for (int i = 0; i < 8; i++) exp_q.push_back(fl[i]);
    crc = 16'hFFFF;
    for (int k = 0; k < len; k++) begin
      byt = mem[k];
      for (int i = 0; i < 8; i++) begin
        raw.push_back(byt[i]);
        crc = crc_upd(crc, byt[i]);
      end
    end
    fcs = ~crc;
    for (int i = 15; i >= 0; i--) raw.push_back(fcs[i]);
    ones = 0;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      ones = (raw[i] == 1'b1) ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(fl[i]);
  endtask

  // Destuff the captured body, compare bytes to the buffer, check residue.
  task automatic check_decode(input int len, input string tag);
    logic [0:0] pay_q[$];
    logic [7:0] byt;
    logic [15:0] crc;
    int ones, six, n, bad_bytes;
    n = bit_q.size();
    ones = 0;
    six = 0;
    for (int i = NFL * 8; i < n - 8; i++) begin
      if (ones == 5) begin
        if (bit_q[i] != 1'b0) six++;
        ones = 0;
      end else begin
        pay_q.push_back(bit_q[i]);
        ones = (bit_q[i] == 1'b1) ? ones + 1 : 0;
      end
    end
    check({tag, "_six_ones"}, six, 0);
    check({tag, "_body_bits"}, pay_q.size(), 8 * len + 16);
    if (pay_q.size() == 8 * len + 16) begin
      bad_bytes = 0;
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < 8; i++) byt[i] = pay_q[8 * k + i];
        if (byt !== mem[k]) bad_bytes++;
      end
      crc = 16'hFFFF;
      foreach (pay_q[i]) crc = crc_upd(crc, pay_q[i]);
      check({tag, "_bytes"}, bad_bytes, 0);
      check({tag, "_residue"}, crc, 16'h1D0F);
    end
  endtask

  task automatic clear_mon();
    bit_q.delete();
    hrd_q.delete();
    done_cnt = 0;
    idle_bad = 0;
  endtask

  // ---- driver: one send request, optional second start at loop cycle second_at ----
  task automatic run_frame(input int len, input int second_at, input string tag);
    int cyc, first_fl, done_at, mism, bad_addr;
    build_exp(len);
    @(negedge clkt); #1;
    clear_mon();
    start = 1'b1;
    @(negedge clkt); #1;
    start = 1'b0;
    cyc = 0;
    first_fl = -1;
    done_at = -1;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clkt); #1;
      cyc++;
      start = (cyc == second_at);
      if (flagt && first_fl < 0) first_fl = cyc;
    end
    start = 1'b0;
    if (done_cnt != 0) done_at = cyc;
    repeat (10) @(negedge clkt);
    #1;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_first_flag"}, first_fl, (len == 0) ? -1 : 2);
    check({tag, "_done_at"}, done_at, exp_q.size() + 2);
    check({tag, "_frame_len"}, bit_q.size(), exp_q.size());
    mism = 0;
    foreach (exp_q[i]) if (i >= bit_q.size() || bit_q[i] !== exp_q[i]) mism++;
    check({tag, "_stream_bits"}, mism, 0);
    check({tag, "_idle_mark"}, idle_bad, 0);
    check({tag, "_hrd_cnt"}, hrd_q.size(), len + 1);
    bad_addr = 0;
    foreach (hrd_q[i]) if (hrd_q[i] != ((i == 0) ? 511 : i - 1)) bad_addr++;
    check({tag, "_hrd_addr"}, bad_addr, 0);
    check({tag, "_busy_after"}, busy, 0);
    if (len > 0) check_decode(len, tag);
  endtask

  // ---- main sequence ----
  initial begin
    int v;
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;

    rst_n = 1'b0;
    repeat (3) @(negedge clkt);
    #1;
    check("rst_datat", datat, 1);
    check("rst_flagt", flagt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hrd", hrd, 0);
    check("rst_rama", rama, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Empty request: one length read, done at T+3, no frame.
    mem[511] = 8'd0;
    run_frame(0, 0, "empty");

    // Single zero byte.
    mem[511] = 8'd1;
    mem[0] = 8'h00;
    run_frame(1, 0, "one_00");

    // Single 0xFF byte: payload section must read 1,1,1,1,1,0,1,1,1.
    mem[0] = 8'hFF;
    run_frame(1, 0, "one_ff");
    v = 0;
    for (int i = NFL * 8; i < NFL * 8 + 9; i++) v = (v << 1) | int'(bit_q[i]);
    check("one_ff_stuff_pattern", v, 9'b111110111);

    // Second start mid-DATA must be ignored.
    mem[511] = 8'd4;
    mem[0] = 8'h7E; mem[1] = 8'hFF; mem[2] = 8'h81; mem[3] = 8'h3C;
    run_frame(4, 25, "busy_start");

    // Reset for one cycle in the middle of DATA.
    mem[511] = 8'd3;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF8;
    @(negedge clkt); #1;
    clear_mon();
    start = 1'b1;
    @(negedge clkt); #1;
    start = 1'b0;
    repeat (25) @(negedge clkt);
    #1;
    check("mid_state_data", dbg_state, 4);
    rst_n = 1'b0;
    @(negedge clkt); #1;
    check("mid_rst_datat", datat, 1);
    check("mid_rst_flagt", flagt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hrd", hrd, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clkt);
    run_frame(3, 0, "after_rst");

    // Maximum length, incrementing data.
    mem[511] = 8'd255;
    for (int i = 0; i < 255; i++) mem[i] = 8'(i);
    run_frame(255, 0, "max");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
